// File: rtl/apb_master_ctrl_if.sv
// Host request/response port plus the two-slave APB bus, grouped for apb_master_ctrl.
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] padd;
    logic [DATA_W-1:0] pwdata;
    logic              PWRITE;
    logic              PSEL1;
    logic              PSEL2;
    logic              PENABLE;
    logic              PREADY;
    logic [DATA_W-1:0] prdata1;
    logic [DATA_W-1:0] prdata2;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PREADY, prdata1, prdata2,
        output req_ready, resp_valid, resp_rdata, resp_err,
               padd, pwdata, PWRITE, PSEL1, PSEL2, PENABLE
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PREADY, prdata1, prdata2,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               padd, pwdata, PWRITE, PSEL1, PSEL2, PENABLE
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB master: single host requests sequenced as SETUP/ACCESS onto a two-slave APB bus.
//   state  | meaning
//   IDLE   | waiting for a host request (only state with req_ready=1)
//   SETUP  | PSELx high, PENABLE low, one cycle
//   ACCESS | PSELx and PENABLE high, waiting on PREADY or timeout
//   RESP   | one-cycle resp_valid pulse, bus released
module apb_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRST,
    apb_master_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic [7:0]        wait_q, wait_d;
    logic              sel2_q, sel2_d;
    logic [ADDR_W-1:0] padd_q, padd_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              psel1_q, psel1_d;
    logic              psel2_q, psel2_d;
    logic              penable_q, penable_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic [1:0]        region;

    // Top two address bits pick the slave; the upper half of the map is unmapped.
    assign region = bus.req_addr[ADDR_W-1 -: 2];

    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            sel2_q    <= 1'b0;
            padd_q    <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            sel2_q    <= sel2_d;
            padd_q    <= padd_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    // Computes next-cycle register values so every bus/response output comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        sel2_d    = sel2_q;
        padd_d    = padd_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel1_d   = 1'b0;
        psel2_d   = 1'b0;
        penable_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (bus.req_valid) begin
                    padd_d   = bus.req_addr;
                    pwdata_d = bus.req_wdata;
                    pwrite_d = bus.req_write;
                    if (region[1]) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        state_d = SETUP;
                        sel2_d  = region[0];
                        psel1_d = ~region[0];
                        psel2_d = region[0];
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                psel1_d   = ~sel2_q;
                psel2_d   = sel2_q;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    state_d  = RESP;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b0;
                    if (pwrite_q)
                        rdata_d = '0;
                    else
                        rdata_d = sel2_q ? bus.prdata2 : bus.prdata1;
                end else begin
                    if (wait_q != TO_CNT)
                        wait_d = wait_q + 8'd1;
                    if (wait_d == TO_CNT) begin
                        state_d  = RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                        rdata_d  = '0;
                    end else begin
                        psel1_d   = ~sel2_q;
                        psel2_d   = sel2_q;
                        penable_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                wait_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = rerr_q;
    assign bus.padd       = padd_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.PWRITE     = pwrite_q;
    assign bus.PSEL1      = psel1_q;
    assign bus.PSEL2      = psel2_q;
    assign bus.PENABLE    = penable_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: transaction-level timeline model, per-cycle compare, directed vectors.
module tb_apb_master_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRST = 1'b1;

    apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    apb_master_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK),
        .PRST(PRST),
        .bus (bus)
    );

    always #5 PCLK = ~PCLK;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: one entry describes the accepted request; expected outputs are
    // derived from the cycle offset since acceptance.
    int         cyc = 0;
    int         n_acc = 0;
    int         drv_nwait = 0;
    logic       m_started = 1'b0;
    int         m_acc = 0;
    int         m_idle_from = 0;
    int         m_a = 0;
    int         m_nwait = 0;
    logic       m_miss = 1'b0;
    logic       m_write = 1'b0;
    logic [7:0] m_addr = '0, m_wdata = '0;
    logic [7:0] m_fin_rd = '0, m_prev_rd = '0;
    logic       m_fin_err = 1'b0, m_prev_err = 1'b0;
    int         last_resp_cyc = -1;

    always @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            m_started = 1'b0; m_idle_from = 0; m_miss = 1'b0; m_write = 1'b0;
            m_addr = '0; m_wdata = '0; m_fin_rd = '0; m_prev_rd = '0;
            m_fin_err = 1'b0; m_prev_err = 1'b0;
        end else begin
            cyc++;
            if (cyc >= m_idle_from && bus.req_valid === 1'b1) begin
                m_prev_rd  = m_fin_rd;
                m_prev_err = m_fin_err;
                m_started  = 1'b1;
                m_acc      = cyc;
                m_write    = bus.req_write;
                m_addr     = bus.req_addr;
                m_wdata    = bus.req_wdata;
                m_nwait    = drv_nwait;
                m_miss     = (bus.req_addr >= 8'h80);
                m_a        = (m_nwait >= TO) ? TO : m_nwait + 1;
                if (m_miss) begin
                    m_fin_err = 1'b1; m_fin_rd = '0; m_idle_from = cyc + 2;
                end else begin
                    m_fin_err   = (m_nwait >= TO);
                    m_fin_rd    = (m_fin_err || m_write) ? 8'h00 :
                                  ((bus.req_addr >= 8'h40) ? bus.prdata2 : bus.prdata1);
                    m_idle_from = cyc + m_a + 3;
                end
                n_acc++;
            end
        end
    end

    // Single compare process; also schedules PREADY for the coming edge.
    always @(negedge PCLK) begin
        logic       e_ready, e_rv, e_err, e_p1, e_p2, e_pen, e_wr, in_acc;
        logic [7:0] e_padd, e_pwd, e_rd;
        int         d, resp_d;
        e_ready = 1'b1; e_rv = 1'b0; e_err = 1'b0; e_p1 = 1'b0; e_p2 = 1'b0;
        e_pen = 1'b0; e_wr = 1'b0; e_padd = '0; e_pwd = '0; e_rd = '0; in_acc = 1'b0;
        d = cyc - m_acc;
        if (PRST && m_started) begin
            e_wr = m_write; e_padd = m_addr; e_pwd = m_wdata;
            resp_d = m_miss ? 0 : m_a + 1;
            e_ready = m_miss ? (d >= 1) : (d >= m_a + 2);
            if (!m_miss && d <= m_a) begin
                e_p1  = (m_addr < 8'h40);
                e_p2  = (m_addr >= 8'h40);
                e_pen = (d >= 1);
                in_acc = (d >= 1);
            end
            e_rv  = (d == resp_d);
            e_rd  = (d >= resp_d) ? m_fin_rd : m_prev_rd;
            e_err = (d >= resp_d) ? m_fin_err : m_prev_err;
        end
        if (bus.resp_valid === 1'b1) last_resp_cyc = cyc;
        check("ctrl{rdy,rv,err,s1,s2,en,wr}",
              {57'd0, bus.req_ready, bus.resp_valid, bus.resp_err, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE},
              {57'd0, e_ready, e_rv, e_err, e_p1, e_p2, e_pen, e_wr});
        check("padd", {56'd0, bus.padd}, {56'd0, e_padd});
        check("pwdata", {56'd0, bus.pwdata}, {56'd0, e_pwd});
        check("resp_rdata", {56'd0, bus.resp_rdata}, {56'd0, e_rd});
        check("psel_overlap", {63'd0, bus.PSEL1 & bus.PSEL2}, 64'd0);
        check("penable_wo_psel", {63'd0, bus.PENABLE & ~(bus.PSEL1 | bus.PSEL2)}, 64'd0);
        if (in_acc) bus.PREADY = ((d - 1) >= m_nwait);
        else        bus.PREADY = 1'($urandom_range(0, 1));
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] wd,
                         input int nw, output int acc);
        int n0;
        n0 = n_acc;
        acc = -1;
        last_resp_cyc = -1;
        @(negedge PCLK);
        bus.req_write = w; bus.req_addr = a; bus.req_wdata = wd;
        drv_nwait = nw; bus.req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge PCLK); #1;
            if (n_acc != n0) begin acc = m_acc; break; end
        end
        if (acc < 0) check("accept_bound", 64'd0, 64'd1);
    endtask

    task automatic finish_txn();
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (cyc >= m_idle_from) break;
            @(negedge PCLK);
        end
        if (cyc < m_idle_from) check("idle_bound", 64'd0, 64'd1);
    endtask

    initial begin
        int a1, a2;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.PREADY = 1'b0; bus.prdata1 = '0; bus.prdata2 = '0;
        #1 PRST = 1'b0;
        #3;
        check("rst_outputs", {39'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.padd, bus.pwdata, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 64'd0);
        check("rst_ready", {63'd0, bus.req_ready}, 64'd1);
        repeat (2) @(negedge PCLK);
        PRST = 1'b1;
        repeat (2) @(negedge PCLK);

        // Zero-wait write to slave2
        bus.prdata1 = 8'h66; bus.prdata2 = 8'h99;
        issue(1'b1, 8'h45, 8'h5A, 0, a1); finish_txn();
        check("wr_latency", 64'(last_resp_cyc - a1), 64'd2);
        check("wr_err_rdata", {55'd0, bus.resp_err, bus.resp_rdata}, 64'd0);

        // Read slave1 with 3 wait states
        bus.prdata1 = 8'hC3; bus.prdata2 = 8'h77;
        issue(1'b0, 8'h05, 8'h00, 3, a1); finish_txn();
        check("wait_latency", 64'(last_resp_cyc - a1), 64'd5);
        check("wait_rdata", {56'd0, bus.resp_rdata}, 64'hC3);

        // Decode miss
        issue(1'b0, 8'h90, 8'h00, 0, a1); finish_txn();
        check("miss_latency", 64'(last_resp_cyc - a1), 64'd0);
        check("miss_err_rdata", {55'd0, bus.resp_err, bus.resp_rdata}, 64'h100);

        // Timeout, then a normal write
        bus.prdata2 = 8'hEE;
        issue(1'b0, 8'h50, 8'h00, 100, a1); finish_txn();
        check("to_latency", 64'(last_resp_cyc - a1), 64'd17);
        check("to_err_rdata", {55'd0, bus.resp_err, bus.resp_rdata}, 64'h100);
        issue(1'b1, 8'h30, 8'h0A, 0, a1); finish_txn();
        check("after_to_err", {63'd0, bus.resp_err}, 64'd0);

        // Back-to-back with req_valid held high
        bus.prdata1 = 8'h11; bus.prdata2 = 8'hA7;
        issue(1'b1, 8'h01, 8'h99, 0, a1);
        issue(1'b0, 8'h41, 8'h00, 2, a2); finish_txn();
        check("b2b_spacing", 64'(a2 - a1), 64'd4);
        check("b2b_rdata", {56'd0, bus.resp_rdata}, 64'hA7);

        // Reset during ACCESS
        bus.prdata1 = 8'h3C;
        issue(1'b0, 8'h10, 8'h00, 100, a1);
        @(negedge PCLK); bus.req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        #2 PRST = 1'b0;
        #1;
        check("arst_outputs", {39'd0, bus.PSEL1, bus.PSEL2, bus.PENABLE, bus.PWRITE, bus.padd, bus.pwdata, bus.resp_valid, bus.resp_err, bus.resp_rdata}, 64'd0);
        check("arst_ready", {63'd0, bus.req_ready}, 64'd1);
        repeat (2) @(negedge PCLK);
        PRST = 1'b1;
        repeat (2) @(negedge PCLK);
        issue(1'b0, 8'h20, 8'h00, 1, a1); finish_txn();
        check("post_rst_latency", 64'(last_resp_cyc - a1), 64'd3);
        check("post_rst_rdata", {55'd0, bus.resp_err, bus.resp_rdata}, 64'h03C);

        repeat (3) @(negedge PCLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
